// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receiver: frame FSM encoding and
// bit positions within the 25-bit ps2_mouse packet bus.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam int BTN_L  = 0;
    localparam int BTN_R  = 1;
    localparam int BTN_M  = 2;
    localparam int SYNC   = 3;
    localparam int XSIGN  = 4;
    localparam int YSIGN  = 5;
    localparam int X_LSB  = 8;
    localparam int Y_LSB  = 16;
    localparam int TOGGLE = 24;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a debounce that only follows the input
// after FILTER consecutive samples disagree with the current filtered level.
module ps2_line_filter #(
    parameter int FILTER = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line_i,
    output logic line_o
);
    localparam int CW = $clog2(FILTER + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            // Any sample agreeing with the current level restarts the run.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign line_o = level_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse host: filters the pins, deframes 11-bit PS/2 frames
// and publishes validated 3-byte packets with a per-packet toggle in bit 24.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0] raw_lines;
    logic [1:0] filt_lines;
    logic       clk_filt;
    logic       data_filt;

    assign raw_lines = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            ps2_line_filter #(.FILTER(FILTER)) u_filter (
                .clk_sys (clk_sys),
                .reset   (reset),
                .line_i  (raw_lines[gi]),
                .line_o  (filt_lines[gi])
            );
        end
    endgenerate

    assign clk_filt  = filt_lines[0];
    assign data_filt = filt_lines[1];

    logic         clk_prev_q;
    logic         fall;
    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;
    logic [1:0]   idx_q, idx_d;
    logic [7:0]   byte0_q, byte0_d;
    logic [7:0]   byte1_q, byte1_d;
    logic [24:0]  mouse_q, mouse_d;
    logic         err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic         active;
    logic         byte_ok;

    assign fall    = clk_prev_q & ~clk_filt;
    assign active  = (state_q != ST_IDLE) || (idx_q != 2'd0);
    assign byte_ok = data_filt && (^{parity_q, shift_q});

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        idx_d     = idx_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        mouse_d   = mouse_q;
        err_d     = 1'b0;
        timer_d   = '0;

        // A falling edge always takes priority over a coincident timeout.
        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_filt) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = data_filt;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!byte_ok) begin
                        err_d = 1'b1;
                        idx_d = 2'd0;
                    end else if (idx_q == 2'd0) begin
                        // Without the always-one sync bit this cannot be a status byte.
                        if (shift_q[SYNC]) begin
                            byte0_d = shift_q;
                            idx_d   = 2'd1;
                        end
                    end else if (idx_q == 2'd1) begin
                        byte1_d = shift_q;
                        idx_d   = 2'd2;
                    end else begin
                        mouse_d = {~mouse_q[TOGGLE], shift_q, byte1_q, byte0_q};
                        idx_d   = 2'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (active) begin
            if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            idx_q      <= 2'd0;
            byte0_q    <= 8'h00;
            byte1_q    <= 8'h00;
            mouse_q    <= 25'h0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            clk_prev_q <= clk_filt;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            idx_q      <= idx_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
            mouse_q    <= mouse_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    assign ps2_mouse = mouse_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: drives PS/2 frames on the pins and
// compares each packet update against a queue of expected packets.
module tb_ps2_mouse_rx;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 40;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [24:0] ps2_mouse;
    logic        err;

    always #5 clk_sys = ~clk_sys;

    ps2_mouse_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_mouse (ps2_mouse),
        .err       (err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    int          toggles  = 0;
    logic        last_tog = 1'b0;
    logic [23:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every toggle of bit 24 must coincide with the next expected packet.
    always @(negedge clk_sys) begin
        if (reset) begin
            last_tog <= ps2_mouse[24];
        end else begin
            if (err) err_seen <= err_seen + 1;
            if (ps2_mouse[24] != last_tog) begin
                logic [23:0] e;
                last_tog <= ps2_mouse[24];
                toggles  <= toggles + 1;
                check_eq("pending_pkts", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("pkt_data", {8'h00, ps2_mouse[23:0]}, {8'h00, e});
                    $display("packet %06h expected %06h", ps2_mouse[23:0], e);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                repeat (HALF / 2) @(posedge clk_sys);
                ps2_clk = 1'b0;
                repeat (3) @(posedge clk_sys);
                ps2_clk = 1'b1;
                repeat (HALF / 2 - 3) @(posedge clk_sys);
            end else begin
                repeat (HALF) @(posedge clk_sys);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_frame(b, bad_par, 11, -1);
        repeat (100) @(posedge clk_sys);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({b2, b1, b0});
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        repeat (50) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        repeat (5) @(posedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check_eq("reset_mouse", {7'h0, ps2_mouse}, 32'h0);
        check_eq("reset_err", {31'h0, err}, 32'h0);
        repeat (20) @(posedge clk_sys);

        // Clean packet
        send_pkt(8'h09, 8'h05, 8'hFB);
        check_eq("clean_mouse", {7'h0, ps2_mouse}, 32'h01FB0509);
        check_eq("clean_toggles", toggles, 1);
        check_eq("clean_err", err_seen, 0);

        // Parity error on the second byte aborts the packet
        send_byte(8'h09, 1'b0);
        send_byte(8'h55, 1'b1);
        @(negedge clk_sys);
        check_eq("parity_err", err_seen, 1);
        check_eq("parity_no_toggle", toggles, 1);
        send_pkt(8'h08, 8'h01, 8'h02);
        check_eq("parity_toggles", toggles, 2);

        // Byte without sync bit at index 0 is dropped silently
        send_byte(8'h00, 1'b0);
        send_pkt(8'h08, 8'h10, 8'h20);
        check_eq("resync_toggles", toggles, 3);
        check_eq("resync_err", err_seen, 1);

        // Partial packet abandoned by the timeout
        send_byte(8'h08, 1'b0);
        send_byte(8'h11, 1'b0);
        repeat (TIMEOUT + 200) @(posedge clk_sys);
        send_pkt(8'h0A, 8'h7F, 8'h80);
        check_eq("timeout_mouse", {8'h0, ps2_mouse[23:0]}, 32'h00807F0A);
        check_eq("timeout_toggles", toggles, 4);

        // Short clock glitches in idle and mid-frame are filtered out
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (50) @(posedge clk_sys);
        exp_q.push_back(24'h332208);
        send_frame(8'h08, 1'b0, 11, 4);
        repeat (100) @(posedge clk_sys);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk_sys);
        check_eq("glitch_toggles", toggles, 5);

        // Reset in the middle of the second byte
        send_byte(8'h08, 1'b0);
        send_frame(8'h5A, 1'b0, 6, -1);
        @(posedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check_eq("midreset_mouse", {7'h0, ps2_mouse}, 32'h0);
        check_eq("midreset_err", {31'h0, err}, 32'h0);
        @(posedge clk_sys);
        reset = 1'b0;
        repeat (100) @(posedge clk_sys);
        send_pkt(8'h08, 8'h33, 8'h44);
        check_eq("postreset_mouse", {7'h0, ps2_mouse}, 32'h01443308);
        check_eq("postreset_toggles", toggles, 6);

        check_eq("total_err", err_seen, 1);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
